// File: rtl/multi_input_conditioner_pkg.sv
// Shared defaults and helpers for the multi-channel input conditioner.
package ic_pkg;

   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_WAIT_TIME   = 3;

   // Width of a counter that must reach wait_time; never narrower than one bit.
   function automatic int counter_width(input int wait_time);
      if (wait_time < 1) begin
         return 1;
      end else begin
         return $clog2(wait_time + 1);
      end
   endfunction

endpackage

// File: rtl/multi_input_conditioner_channel.sv
// One conditioner lane: pin synchroniser, stability counter, debounced level
// and single-cycle edge pulses.
module conditioner_channel
   import ic_pkg::*;
#(
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   WAIT_TIME   = DEF_WAIT_TIME,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic noisysignal,
   output logic conditioned,
   output logic positiveedge,
   output logic negativeedge
);

   localparam int CW = counter_width(WAIT_TIME);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   synced;
   logic [CW-1:0]          count;

   assign synced = sync_chain[SYNC_STAGES-1];

   // Synchroniser chain; keeps running while the lane is disabled so the
   // level is current when debouncing resumes.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_chain <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], noisysignal};
      end
   end

   // Debounce: accept the synced level only after WAIT_TIME+1 consecutive
   // enabled mismatch cycles; pulses default low so each lasts one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         conditioned  <= RESET_LEVEL;
         count        <= {CW{1'b0}};
         positiveedge <= 1'b0;
         negativeedge <= 1'b0;
      end else begin
         positiveedge <= 1'b0;
         negativeedge <= 1'b0;
         if (!enable) begin
            count <= {CW{1'b0}};
         end else if (synced == conditioned) begin
            count <= {CW{1'b0}};
         end else if (count == CW'(WAIT_TIME)) begin
            conditioned  <= synced;
            count        <= {CW{1'b0}};
            positiveedge <= synced;
            negativeedge <= ~synced;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/multi_input_conditioner.sv
// Multi-channel input conditioner: independent lanes plus aggregate edge flags.
module multi_input_conditioner
   import ic_pkg::*;
#(
   parameter int   CHANNELS    = DEF_CHANNELS,
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   WAIT_TIME   = DEF_WAIT_TIME,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] enable,
   input  logic [CHANNELS-1:0] noisysignal,
   output logic [CHANNELS-1:0] conditioned,
   output logic [CHANNELS-1:0] positiveedge,
   output logic [CHANNELS-1:0] negativeedge,
   output logic                any_positiveedge,
   output logic                any_negativeedge
);

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
      conditioner_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .WAIT_TIME   (WAIT_TIME),
         .RESET_LEVEL (RESET_LEVEL)
      ) u_lane (
         .clk          (clk),
         .reset        (reset),
         .enable       (enable[ch]),
         .noisysignal  (noisysignal[ch]),
         .conditioned  (conditioned[ch]),
         .positiveedge (positiveedge[ch]),
         .negativeedge (negativeedge[ch])
      );
   end

   // Pulse vectors are registered, so these reductions cannot glitch.
   assign any_positiveedge = |positiveedge;
   assign any_negativeedge = |negativeedge;

endmodule

// File: doc/multi_input_conditioner.md
Name: multi_input_conditioner

Overview:
Parametrised, multi-channel successor to the single-bit input conditioner.
Each channel synchronises an asynchronous pin, debounces it with a stability counter, and emits one-cycle rising/falling edge pulses.
Adds per-channel enable, configurable synchroniser depth and debounce time, a defined reset level, and aggregate any-edge flags.
Sits between board pins (buttons/switches) and the synchronous datapath.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
WAIT_TIME, 3, cycles synced input must differ from conditioned before it is accepted (>=1)
RESET_LEVEL, 1'b0, value loaded into sync chain and conditioned on reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
enable  input  CHANNELS  per-channel enable; 0 freezes debounce for that channel
noisysignal  input  CHANNELS  raw asynchronous pin inputs
conditioned  output  CHANNELS  debounced, synchronised level per channel
positiveedge  output  CHANNELS  one-cycle pulse on conditioned 0->1
negativeedge  output  CHANNELS  one-cycle pulse on conditioned 1->0
any_positiveedge  output  1  OR of positiveedge
any_negativeedge  output  1  OR of negativeedge

Behaviour:
- Reset (sampled high at clk edge): all sync flops = RESET_LEVEL, conditioned = {CHANNELS{RESET_LEVEL}}, counters = 0, positiveedge = negativeedge = 0. Reset dominates enable and noisysignal. Mid-debounce reset discards the pending change. No edge pulse is generated by reset or on the first cycle after it.
- Synchroniser: SYNC_STAGES-deep shift chain per channel, always running (including while enable = 0). synced = last stage.
- Counter width: $clog2(WAIT_TIME+1).
- Per channel, each edge when not in reset:
  - Default: edge pulses are cleared to 0 every cycle unless set below, so every pulse is exactly 1 cycle.
  - enable = 0: counter <= 0; conditioned holds; no pulses.
  - synced == conditioned: counter <= 0.
  - synced != conditioned and counter == WAIT_TIME: conditioned <= synced; counter <= 0; positiveedge <= synced; negativeedge <= ~synced.
  - Otherwise: counter <= counter + 1.
- Latency: a pin change stable from before edge k updates conditioned and pulses at edge k + SYNC_STAGES + WAIT_TIME. Defaults give 5 cycles.
- Glitch rejection: any excursion of synced lasting <= WAIT_TIME cycles restarts the counter and produces no change.
- Re-enable: counting restarts from 0; a level that changed while disabled is accepted after the full WAIT_TIME+1 mismatch cycles.
- Channels are fully independent. Simultaneous edges on several channels are all reported in the same cycle.
- any_* outputs are combinational ORs of the registered pulse vectors (same cycle, glitch-free).
- positiveedge and negativeedge are never both 1 on a channel.

Decomposition:
- Package ic_pkg holds default constants (DEF_CHANNELS, DEF_SYNC_STAGES, DEF_WAIT_TIME) and the counter-width function.
- Sub-module conditioner_channel (one bit: sync chain, counter, conditioned, edge regs), instantiated CHANNELS times by generate.
- The top level holds only the generate loop and the OR reductions.

Test Plan:
(defaults, clk period 10)
- Reset: pins = 4'b1111, reset high 2 cycles then low -> conditioned = 4'b0000 during reset; no pulses; ch0-3 rise 5 cycles after reset release (pins synced after deassert) with positiveedge = 4'b1111 for 1 cycle and any_positiveedge = 1.
- Latency: ch0 0->1 just before edge k -> conditioned[0] = 1 and positiveedge[0] = 1 exactly at edge k+5, 0 at k+6; other channels unchanged.
- Glitch: ch1 pin toggles 1,0,1,0 every 3 time units then returns to prior level, or holds a new level for only 3 cycles -> no change on conditioned[1], no pulses.
- Falling and simultaneous: ch2 and ch3 1->0 on the same cycle -> negativeedge = 4'b1100 for one cycle; any_negativeedge = 1; any_positiveedge = 0.
- Enable: enable[0] = 0, pin[0] toggles and holds 20 cycles -> conditioned[0] frozen, no pulse; enable[0] = 1 -> update after 4 cycles (WAIT_TIME+1).
- Reset mid-debounce: ch1 change pending, counter = 2, reset asserted -> conditioned[1] = RESET_LEVEL, no pulse on the following cycle.
